// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter.
//   state_t      : access type granted in a cycle (also the response owner
//                  for the following cycle)
//   owner_t      : which requester receives the memory read data
//   owner_of()   : maps a registered grant state to its response owner
//   STARVE_LIMIT_DEF / STARVE_W : default fetch starvation limit and the
//                  width of the starvation counter (limit range 1..15)
package mem_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_IF    = 2'd1,
      S_DM_RD = 2'd2,
      S_DM_WR = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2
   } owner_t;

   localparam int STARVE_LIMIT_DEF = 3;
   localparam int STARVE_W         = 4;

   // Stores and idle cycles produce no read response.
   function automatic owner_t owner_of(input state_t s);
      case (s)
         S_IF:    owner_of = OWN_IF;
         S_DM_RD: owner_of = OWN_DM;
         default: owner_of = OWN_NONE;
      endcase
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   inc          : count up by one unless already at MAX
//   clr          : return to zero (wins over inc)
//   count        : current value
module sat_counter #(
   parameter int           W   = 4,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != MAX)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous 256x8 memory between instruction
// fetch and EXEC-stage data access. Data access wins unless fetch has been
// denied STARVE_LIMIT cycles in a row, in which case fetch is forced through
// for one cycle. Read data arrives one cycle after the grant and is steered
// to the owning requester, then held until that requester's next response.
//   clock, reset                 : clock / async active-high reset
//   if_req, if_addr              : fetch read request
//   if_gnt, if_rdata, if_valid   : fetch grant, instruction data, data strobe
//   dm_req, dm_we, dm_addr,
//   dm_wdata                     : data load/store request
//   dm_gnt, dm_rdata, dm_valid   : data grant, load data, load strobe
//   mem_addr, mem_wdata,
//   mem_wren, mem_q              : memory port (mem_q one cycle after addr)
//   stall_fetch, stall_data      : requester waiting this cycle
//   stall_count                  : saturating count of stalled cycles
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
   parameter int CNT_W        = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             if_req,
   input  logic [7:0]       if_addr,
   output logic             if_gnt,
   output logic [7:0]       if_rdata,
   output logic             if_valid,
   input  logic             dm_req,
   input  logic             dm_we,
   input  logic [7:0]       dm_addr,
   input  logic [7:0]       dm_wdata,
   output logic             dm_gnt,
   output logic [7:0]       dm_rdata,
   output logic             dm_valid,
   output logic [7:0]       mem_addr,
   output logic [7:0]       mem_wdata,
   output logic             mem_wren,
   input  logic [7:0]       mem_q,
   output logic             stall_fetch,
   output logic             stall_data,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   logic [STARVE_W-1:0] starve_cnt;
   logic                force_if;
   state_t              state;
   state_t              state_next;
   owner_t              resp_owner;
   logic [7:0]          if_hold;
   logic [7:0]          dm_hold;

   // Grant and memory drive for the current cycle
   always_comb begin
      force_if    = (starve_cnt == STARVE_MAX);
      dm_gnt      = dm_req & ~(force_if & if_req);
      if_gnt      = if_req & ~dm_gnt;
      stall_fetch = if_req & ~if_gnt;
      stall_data  = dm_req & ~dm_gnt;

      mem_addr   = 8'h00;
      mem_wdata  = 8'h00;
      mem_wren   = 1'b0;
      state_next = S_IDLE;
      if (dm_gnt) begin
         mem_addr   = dm_addr;
         mem_wdata  = dm_wdata;
         mem_wren   = dm_we;
         state_next = dm_we ? S_DM_WR : S_DM_RD;
      end else if (if_gnt) begin
         mem_addr   = if_addr;
         state_next = S_IF;
      end
   end

   // Grant state register: last cycle's grant owns this cycle's mem_q
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         if_hold <= 8'h00;
         dm_hold <= 8'h00;
      end else begin
         state <= state_next;
         if (resp_owner == OWN_IF) if_hold <= mem_q;
         if (resp_owner == OWN_DM) dm_hold <= mem_q;
      end
   end

   // Response steering: mem_q is passed through in its response cycle so the
   // requester sees the data one cycle after its grant; the hold registers
   // keep it afterwards.
   always_comb begin
      resp_owner = owner_of(state);
      if_valid   = (resp_owner == OWN_IF);
      dm_valid   = (resp_owner == OWN_DM);
      if_rdata   = if_valid ? mem_q : if_hold;
      dm_rdata   = dm_valid ? mem_q : dm_hold;
   end

   // A forced fetch grant also clears the counter, so data is denied once.
   sat_counter #(
      .W   (STARVE_W),
      .MAX (STARVE_MAX)
   ) u_starve (
      .clock (clock),
      .reset (reset),
      .inc   (stall_fetch),
      .clr   (if_gnt | ~if_req),
      .count (starve_cnt)
   );

   sat_counter #(
      .W   (CNT_W),
      .MAX ({CNT_W{1'b1}})
   ) u_stall (
      .clock (clock),
      .reset (reset),
      .inc   (stall_fetch | stall_data),
      .clr   (1'b0),
      .count (stall_count)
   );

endmodule
